fsm_calibration_multi: RTL and testbench

- Parametrised successor of the single-output calibration sequencer.
- Arms on a start edge, waits for the frame-grabber edge and a fixed open delay, then waits for a phase edge plus a phase shift.
- Fires N independently delayed and lengthened trigger pulses, repeated over a programmable number of phase edges.
- Sits between the synchronization-block control inputs and the camera/laser trigger outputs.

---
 rtl/fsm_calibration_multi.sv | 242 ++++++++++++++++++++++++
 tb/tb_fsm_calibration_multi.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_calibration_multi.sv
// fsm_calibration_multi: multi-channel calibration trigger sequencer.
// The sequencer arms on a start edge, waits for the frame-grabber edge and a fixed
// open delay, and then waits for a phase edge and a phase shift. It then fires NUM_CH
// delayed pulses, and this repeats for repeat_count phase edges.
// Build macro FSM_CALIB_TIMEOUT_EN: when defined, the WAIT_FG and WAIT_PHASE states are
// bounded to WAIT_TIMEOUT cycles and fall into TIMEOUT. When undefined, both waits are
// unbounded and timeout_err stays 0.
module fsm_calibration_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CW           = 32,
  parameter int unsigned DW           = 16,
  parameter int unsigned FG_DELAY     = 1_800_000,
  parameter int unsigned PHASE_SHIFT  = 140,
  parameter int unsigned WAIT_TIMEOUT = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset_signal,
  input  logic                 start_signal,
  input  logic                 fg_signal,
  input  logic                 phase_signal,
  input  logic                 abort_signal,
  input  logic [7:0]           repeat_count,
  input  logic [NUM_CH*DW-1:0] ch_delay,
  input  logic [NUM_CH*DW-1:0] ch_len,
  output logic [NUM_CH-1:0]    output_trigger,
  output logic [2:0]           scenario_state,
  output logic [CW-1:0]        counter_out,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int unsigned WW = DW + 1;
  localparam int unsigned MW = (CW > WW) ? CW : WW;
  localparam int unsigned BW = 8;

`ifdef FSM_CALIB_TIMEOUT_EN
  localparam logic TIMEOUT_ON = 1'b1;
`else
  localparam logic TIMEOUT_ON = 1'b0;
`endif

  localparam logic [CW-1:0] FG_LAST = CW'(FG_DELAY - 1);
  localparam logic [CW-1:0] PS_LAST = CW'(PHASE_SHIFT - 1);
  localparam logic [CW-1:0] WT_LAST = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_FG     = 3'd1,
    S_FG_OPEN     = 3'd2,
    S_WAIT_PHASE  = 3'd3,
    S_PHASE_DELAY = 3'd4,
    S_FIRE        = 3'd5,
    S_TIMEOUT     = 3'd6
  } state_t;

  // bit 0 = start, bit 1 = fg, bit 2 = phase
  logic [2:0] sync1, sync2, prev, edge_q;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n, cnt_inc;
  logic [BW-1:0]      bursts, bursts_n;
  logic [NUM_CH*DW-1:0] lat_delay, lat_len;
  logic [WW-1:0]      window, win_c, sum_c;
  logic [NUM_CH-1:0]  trig, trig_n;
  logic               busy_q, done_q, done_n, tmo_q, tmo_n, latch;
  logic               start_ev, fg_ev, phase_ev, fire_last;

  assign start_ev = edge_q[0];
  assign fg_ev    = edge_q[1];
  assign phase_ev = edge_q[2];

  // Two-stage synchronizers followed by a registered rising-edge detector
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= {phase_signal, fg_signal, start_signal};
      sync2  <= sync1;
      prev   <= sync2;
      edge_q <= sync2 & ~prev;
    end
  end

  // The FIRE window is the latest end point over all channels, from the live inputs
  always_comb begin
    win_c = '0;
    sum_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      sum_c = WW'(ch_delay[i*DW +: DW]) + WW'(ch_len[i*DW +: DW]);
      if (sum_c > win_c) win_c = sum_c;
    end
  end

  assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign fire_last = (window == '0) || ((MW'(cnt) + MW'(1)) == MW'(window));

  // Next-state, counter, burst and status decode
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bursts_n = bursts;
    done_n   = 1'b0;
    tmo_n    = tmo_q;
    latch    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start_ev && !abort_signal) begin
          state_n  = S_WAIT_FG;
          latch    = 1'b1;
          bursts_n = (repeat_count == 8'd0) ? 8'd1 : repeat_count;
          tmo_n    = 1'b0;
        end
      end
      S_WAIT_FG: begin
        if (fg_ev) begin
          state_n = S_FG_OPEN;
          cnt_n   = '0;
        end else if (TIMEOUT_ON && (cnt == WT_LAST)) begin
          state_n = S_TIMEOUT;
          cnt_n   = '0;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = TIMEOUT_ON ? cnt_inc : '0;
        end
      end
      S_FG_OPEN: begin
        if (cnt == FG_LAST) begin
          state_n = S_WAIT_PHASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT_PHASE: begin
        if (phase_ev) begin
          state_n = S_PHASE_DELAY;
          cnt_n   = '0;
        end else if (TIMEOUT_ON && (cnt == WT_LAST)) begin
          state_n = S_TIMEOUT;
          cnt_n   = '0;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = TIMEOUT_ON ? cnt_inc : '0;
        end
      end
      S_PHASE_DELAY: begin
        if (cnt == PS_LAST) begin
          state_n = S_FIRE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_FIRE: begin
        if (fire_last) begin
          cnt_n = '0;
          if (bursts > 8'd1) begin
            state_n  = S_WAIT_PHASE;
            bursts_n = bursts - 8'd1;
          end else begin
            state_n  = S_IDLE;
            bursts_n = '0;
            done_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_TIMEOUT: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    // Abort wins over every transition out of a non-idle state
    if (abort_signal && (state != S_IDLE)) begin
      state_n  = S_IDLE;
      cnt_n    = '0;
      bursts_n = '0;
      done_n   = 1'b0;
    end
  end

  // Trigger levels for the next cycle so that they line up with the state and counter
  always_comb begin
    trig_n = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      trig_n[i] = (state_n == S_FIRE)
               && (MW'(cnt_n) >= MW'(lat_delay[i*DW +: DW]))
               && (MW'(cnt_n) < (MW'(lat_delay[i*DW +: DW]) + MW'(lat_len[i*DW +: DW])));
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset_signal) state <= S_IDLE;
    else              state <= state_n;
  end

  // Counter, burst bookkeeping, latched configuration and registered outputs
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      cnt       <= '0;
      bursts    <= '0;
      lat_delay <= '0;
      lat_len   <= '0;
      window    <= '0;
      trig      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      bursts <= bursts_n;
      if (latch) begin
        lat_delay <= ch_delay;
        lat_len   <= ch_len;
        window    <= win_c;
      end
      trig   <= trig_n;
      busy_q <= (state_n != S_IDLE);
      done_q <= done_n;
      tmo_q  <= tmo_n;
    end
  end

  assign output_trigger = trig;
  assign scenario_state = state;
  assign counter_out    = cnt;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_fsm_calibration_multi.sv
// Testbench for fsm_calibration_multi. It compares the DUT on every cycle against a
// timestamp-based behavioural model, and adds a few hand-computed literal checks.
module tb_fsm_calibration_multi;

  localparam int unsigned NUM_CH       = 2;
  localparam int unsigned CW           = 32;
  localparam int unsigned DW           = 8;
  localparam int unsigned FG_DELAY     = 20;
  localparam int unsigned PHASE_SHIFT  = 5;
  localparam int unsigned WAIT_TIMEOUT = 100;

`ifdef FSM_CALIB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic                 clock;
  logic                 reset_signal;
  logic                 start_signal;
  logic                 fg_signal;
  logic                 phase_signal;
  logic                 abort_signal;
  logic [7:0]           repeat_count;
  logic [NUM_CH*DW-1:0] ch_delay;
  logic [NUM_CH*DW-1:0] ch_len;
  logic [NUM_CH-1:0]    output_trigger;
  logic [2:0]           scenario_state;
  logic [CW-1:0]        counter_out;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  int total = 0;
  int bad   = 0;

  fsm_calibration_multi #(
    .NUM_CH(NUM_CH), .CW(CW), .DW(DW), .FG_DELAY(FG_DELAY),
    .PHASE_SHIFT(PHASE_SHIFT), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .start_signal(start_signal),
    .fg_signal(fg_signal), .phase_signal(phase_signal), .abort_signal(abort_signal),
    .repeat_count(repeat_count), .ch_delay(ch_delay), .ch_len(ch_len),
    .output_trigger(output_trigger), .scenario_state(scenario_state),
    .counter_out(counter_out), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (phase + start timestamp) ----------------
  bit m_valid = 1'b0;
  int m_md = 0;        // visible state code
  int m_t0 = 0;        // cycle at which the current phase began
  int m_bursts = 0;
  int m_window = 0;
  bit m_done = 1'b0;
  bit m_tmo = 1'b0;
  int m_delay[NUM_CH];
  int m_len[NUM_CH];
  bit [4:0] hs = '0, hf = '0, hp = '0;   // input history, [0] = this cycle
  int cyc = 0;

  // Check the current cycle, then advance the model with the inputs the DUT samples next
  always @(negedge clock) begin
    int c;
    int ec;
    logic [NUM_CH-1:0] et;
    bit s_ev, f_ev, p_ev;
    if (m_valid) begin
      c  = cyc - m_t0;
      ec = 0;
      if (m_md == 2 || m_md == 4 || m_md == 5) ec = c;
      if (TMO && (m_md == 1 || m_md == 3)) ec = c;
      et = '0;
      if (m_md == 5)
        for (int i = 0; i < int'(NUM_CH); i++)
          et[i] = (c >= m_delay[i]) && (c < m_delay[i] + m_len[i]);
      chk("model_state",   scenario_state, m_md);
      chk("model_counter", counter_out, ec);
      chk("model_trigger", output_trigger, et);
      chk("model_busy",    busy, (m_md != 0));
      chk("model_done",    done, m_done);
      chk("model_timeout", timeout_err, m_tmo);
    end
    hs = {hs[3:0], start_signal};
    hf = {hf[3:0], fg_signal};
    hp = {hp[3:0], phase_signal};
    s_ev = hs[3] & ~hs[4];
    f_ev = hf[3] & ~hf[4];
    p_ev = hp[3] & ~hp[4];
    c = cyc - m_t0;
    m_done = 1'b0;
    if (reset_signal) begin
      m_valid = 1'b1; m_md = 0; m_bursts = 0; m_tmo = 1'b0;
      hs = '0; hf = '0; hp = '0;
    end else if (m_md != 0 && abort_signal) begin
      m_md = 0;
    end else begin
      case (m_md)
        0: if (s_ev && !abort_signal) begin
             m_window = 0;
             for (int i = 0; i < int'(NUM_CH); i++) begin
               m_delay[i] = int'(ch_delay[i*DW +: DW]);
               m_len[i]   = int'(ch_len[i*DW +: DW]);
               if (m_delay[i] + m_len[i] > m_window) m_window = m_delay[i] + m_len[i];
             end
             m_bursts = (repeat_count == 0) ? 1 : int'(repeat_count);
             m_tmo = 1'b0; m_md = 1; m_t0 = cyc + 1;
           end
        1: if (f_ev) begin m_md = 2; m_t0 = cyc + 1; end
           else if (TMO && c == int'(WAIT_TIMEOUT) - 1) begin m_md = 6; m_tmo = 1'b1; end
        2: if (c == int'(FG_DELAY) - 1) begin m_md = 3; m_t0 = cyc + 1; end
        3: if (p_ev) begin m_md = 4; m_t0 = cyc + 1; end
           else if (TMO && c == int'(WAIT_TIMEOUT) - 1) begin m_md = 6; m_tmo = 1'b1; end
        4: if (c == int'(PHASE_SHIFT) - 1) begin m_md = 5; m_t0 = cyc + 1; end
        5: if (c >= ((m_window == 0) ? 0 : m_window - 1)) begin
             m_bursts--;
             if (m_bursts > 0) begin m_md = 3; m_t0 = cyc + 1; end
             else begin m_md = 0; m_done = 1'b1; end
           end
        default: m_md = 0;
      endcase
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int which, input logic v);
    case (which)
      0: start_signal = v;
      1: fg_signal    = v;
      default: phase_signal = v;
    endcase
  endtask

  task automatic pulse(input int which);
    set_in(which, 1'b1); tick(); tick();
    set_in(which, 1'b0); tick();
  endtask

  task automatic wait_state(input int code, input int budget, input string tag);
    int n = 0;
    while (int'(scenario_state) != code && n < budget) begin tick(); n++; end
    chk({"wait_", tag}, scenario_state, code);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},   scenario_state, 0);
    chk({tag, "_counter"}, counter_out, 0);
    chk({tag, "_trigger"}, output_trigger, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_timeout"}, timeout_err, 0);
  endtask

  task automatic arm_to_phase();
    pulse(0); wait_state(1, 10, "arm");
    pulse(1); wait_state(2, 10, "fg_open");
    wait_state(3, 40, "wait_phase");
    pulse(2);
  endtask

  task automatic run_seq(input int rep, input int nb, input bit ign,
                         input logic [NUM_CH*DW-1:0] dly, input logic [NUM_CH*DW-1:0] len);
    repeat_count = 8'(rep); ch_delay = dly; ch_len = len;
    pulse(0); wait_state(1, 10, "seq_arm");
    pulse(1); wait_state(2, 10, "seq_fg_open");
    if (ign) begin pulse(0); pulse(1); end
    for (int b = 0; b < nb; b++) begin
      wait_state(3, 40, "seq_wait_phase");
      pulse(2);
      wait_state(5, 40, "seq_fire");
      if (ign) pulse(1);
    end
    wait_state(0, 60, "seq_idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] lit [5];
    lit = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
    reset_signal = 1'b1; start_signal = 1'b0; fg_signal = 1'b0; phase_signal = 1'b0;
    abort_signal = 1'b0; repeat_count = 8'd1; ch_delay = '0; ch_len = '0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset_signal = 1'b0;
    tick();

    // single burst: delay {0,3}, len {4,2}
    repeat_count = 8'd1; ch_delay = {8'd3, 8'd0}; ch_len = {8'd2, 8'd4};
    arm_to_phase();
    wait_state(5, 40, "single_fire");
    for (int c = 0; c < 5; c++) begin
      chk("single_counter", counter_out, c);
      chk("single_trigger", output_trigger, lit[c]);
      tick();
    end
    chk("single_end_state", scenario_state, 0);
    chk("single_done", done, 1);
    chk("single_busy", busy, 0);
    tick();
    chk("single_done_once", done, 0);

    // repeated bursts, zero repeat, ignored edges, zero-length channel
    run_seq(3, 3, 1'b0, {8'd3, 8'd0}, {8'd2, 8'd4});
    run_seq(0, 1, 1'b0, {8'd1, 8'd2}, {8'd3, 8'd1});
    run_seq(2, 2, 1'b1, {8'd2, 8'd5}, {8'd3, 8'd0});
    run_seq(1, 1, 1'b0, {8'd0, 8'd0}, {8'd0, 8'd0});

    // abort at FIRE c=2, then re-arm
    repeat_count = 8'd1; ch_delay = {8'd3, 8'd0}; ch_len = {8'd2, 8'd4};
    arm_to_phase();
    wait_state(5, 40, "abort_fire");
    tick(); tick();
    chk("abort_c2", counter_out, 2);
    abort_signal = 1'b1; tick(); abort_signal = 1'b0;
    chk("abort_state", scenario_state, 0);
    chk("abort_trigger", output_trigger, 0);
    chk("abort_done", done, 0);
    run_seq(1, 1, 1'b0, {8'd1, 8'd1}, {8'd1, 8'd2});

    // reset in PHASE_DELAY and in FIRE
    arm_to_phase();
    wait_state(4, 10, "rst_phase_delay");
    reset_signal = 1'b1; tick(); reset_signal = 1'b0;
    check_reset_outputs("rst_pd");
    arm_to_phase();
    wait_state(5, 40, "rst_fire");
    tick();
    reset_signal = 1'b1; tick(); reset_signal = 1'b0;
    check_reset_outputs("rst_fire");

`ifdef FSM_CALIB_TIMEOUT_EN
    pulse(0); wait_state(1, 10, "tmo_arm");
    pulse(1); wait_state(3, 40, "tmo_wait_phase");
    wait_state(6, 150, "tmo_state");
    chk("tmo_flag", timeout_err, 1);
    tick();
    chk("tmo_to_idle", scenario_state, 0);
    chk("tmo_sticky", timeout_err, 1);
    pulse(0); wait_state(1, 10, "tmo_rearm");
    chk("tmo_cleared", timeout_err, 0);
    abort_signal = 1'b1; tick(); abort_signal = 1'b0;
`else
    pulse(0); wait_state(1, 10, "nt_arm");
    pulse(1); wait_state(3, 40, "nt_wait_phase");
    repeat (300) tick();
    chk("nt_still_waiting", scenario_state, 3);
    chk("nt_counter_hold", counter_out, 0);
    chk("nt_no_timeout", timeout_err, 0);
    abort_signal = 1'b1; tick(); abort_signal = 1'b0;
`endif
    tick();

    // free-running random stimulus
    for (int n = 0; n < 6000; n++) begin
      start_signal = ($urandom_range(0, 11) == 0);
      fg_signal    = ($urandom_range(0, 7) == 0);
      phase_signal = ($urandom_range(0, 5) == 0);
      abort_signal = ($urandom_range(0, 199) == 0);
      reset_signal = ($urandom_range(0, 1499) == 0);
      repeat_count = 8'($urandom_range(0, 3));
      for (int i = 0; i < int'(NUM_CH); i++) begin
        ch_delay[i*DW +: DW] = 8'($urandom_range(0, 7));
        ch_len[i*DW +: DW]   = 8'($urandom_range(0, 7));
      end
      tick();
    end
    reset_signal = 1'b0; abort_signal = 1'b0;
    start_signal = 1'b0; fg_signal = 1'b0; phase_signal = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
